inst_mem_responder: RTL and testbench
=====================================

# inst_mem_responder

Word-addressed instruction memory that serves fetch requests from the fetch stage through a valid/ready request channel and a one-cycle response pulse, after a fixed, parameterised number of wait cycles. A branch-taken abort input cancels an in-flight fetch. A write port lets the bench or boot logic load the program. It replaces the hard-wired instruction table and lets the fetch stage work with multi-cycle memory.

## Interface
- DEPTH, 64: number of 32-bit instruction words; must be a power of two, 2..1024.
- LATENCY, 2: wait cycles between request acceptance and response; legal range 0..15.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset; all state is cleared immediately while low.
- req_valid  input  1  the fetch stage presents a request.
- req_ready  output  1  the block accepts a request this cycle.
- req_addr  input  32  word address (the PC, which counts in words).
- abort  input  1  branch taken; cancels any in-flight request.
- resp_valid  output  1  single-cycle response strobe.
- resp_addr  output  32  address of the request being answered.
- resp_inst  output  32  instruction word.
- resp_err  output  1  the address was out of range.
- ld_en  input  1  write enable for the program.
- ld_addr  input  log2(DEPTH)  write word index.
- ld_data  input  32  write data.

## Operation
- The FSM has three states: IDLE, WAIT and RESP. It enters IDLE on reset.
- **IDLE:**
  - req_ready=1.
  - A request is accepted on an edge where req_valid=1 and abort=0.
  - On acceptance, capture req_addr and load the 4-bit counter with LATENCY.
  - Next state is WAIT, or RESP if LATENCY=0.
  - If abort=1, no request is accepted.
- **WAIT:**
  - req_ready=0.
  - The counter decrements each edge.
  - On the edge where the counter equals 1, go to RESP.
  - On that same edge, register resp_inst, resp_addr and resp_err from the captured address.
  - If LATENCY=0, the registration happens on the acceptance edge instead.
- **RESP:**
  - req_ready=0.
  - resp_valid = (state==RESP) & ~abort, combinational.
  - Next state is always IDLE.
- **Abort:** abort=1 in WAIT or RESP sends the FSM to IDLE on the next edge. No resp_valid is produced for that request, including in the abort cycle itself.
- **Range check:**
  - A captured address >= DEPTH gives resp_inst=32'h0 (NOP) and resp_err=1.
  - Otherwise resp_inst = mem[addr[log2(DEPTH)-1:0]] and resp_err=0.
- **Load port:**
  - When ld_en=1, mem[ld_addr] <= ld_data on the edge. This works in any state.
  - A write on the same edge that registers resp_inst is not visible: resp_inst gets the old word.
  - The write is visible to responses registered on later edges.
- resp_inst, resp_addr and resp_err hold their values outside RESP. Only resp_valid qualifies them.
- req_addr is sampled only on the acceptance edge. Changes to it during WAIT are ignored.

## Timing
- **Reset (rst=0):**
  - state=IDLE, counter=0, resp_valid=0, resp_inst=0, resp_addr=0, resp_err=0.
  - All DEPTH memory words are cleared to 0.
  - req_ready is 1 once reset is released. It is 1 during reset as well, but no requests are accepted while rst=0.
- **Latency:** with the acceptance edge numbered 0, resp_valid is high from edge LATENCY to edge LATENCY+1.
- **Throughput:** at most one request every LATENCY+2 cycles. Ready returns in the cycle after RESP.
- **Reset mid-operation:** pending requests are dropped and no response is issued. Memory contents are also cleared, so the program must be reloaded.
- **Simultaneous req_valid and abort in IDLE:** the request is not accepted.
- **Abort on the edge that would move WAIT→RESP:** the FSM goes to IDLE, and the registered outputs may still update without a strobe.

## Test plan
- **Load and fetch:**
  - Stimulus: LATENCY=2; load mem[3]=32'h00221000; request addr 3 accepted at edge 0.
  - Required: resp_valid is high only between edges 2 and 3, with resp_inst=32'h00221000, resp_addr=3, resp_err=0.
  - Required: req_ready is 0 between edges 0 and 3.
- **Zero latency:**
  - Stimulus: LATENCY=0; back-to-back requests for addresses 0, 1 and 2 with req_valid held high.
  - Required: a response every 2 cycles, in order, with correct words.
- **Out of range:**
  - Stimulus: DEPTH=64; request addr 64.
  - Required: resp_inst=0, resp_err=1, resp_valid pulses once.
- **Abort:**
  - Stimulus: LATENCY=3; abort=1 one cycle after acceptance.
  - Required: no resp_valid; req_ready=1 in the next cycle; a new request for addr 5 is served normally.
- **Write collision:**
  - Stimulus: ld_en writes mem[3]=32'hDEAD0000 on the registering edge of a fetch of addr 3.
  - Required: the response carries the old word, and the next fetch of addr 3 returns 32'hDEAD0000.
- **Async reset:**
  - Stimulus: assert rst=0 mid-WAIT, asynchronously between edges.
  - Required: outputs go to their reset values immediately, and no response follows.

Source files
------------

// File: rtl/inst_mem_responder.sv
// Word-addressed instruction memory with a valid/ready fetch channel, a fixed-latency
// single-cycle response strobe, branch abort, and a program load port.
module inst_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic                     abort,
  output logic                     resp_valid,
  output logic [31:0]              resp_addr,
  output logic [31:0]              resp_inst,
  output logic                     resp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] cap_addr;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        reg_now;
  logic [31:0] src_addr;
  logic        in_range;
  logic [31:0] rd_word;

  assign accept = (state == IDLE) && req_valid && !abort;

  // With zero latency the response is registered straight from the request on the
  // acceptance edge; otherwise from the captured address on the last WAIT edge.
  assign reg_now  = (LATENCY == 0) ? accept : ((state == WAIT) && (cnt == 4'd1));
  assign src_addr = (LATENCY == 0) ? req_addr : cap_addr;
  assign in_range = (src_addr[31:AW] == '0);
  assign rd_word  = mem[src_addr[AW-1:0]];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT: begin
        if (abort)               state_nxt = IDLE;
        else if (cnt == 4'd1)    state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; abort suppresses the strobe in the same cycle
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP) && !abort;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      cap_addr <= '0;
    end else if (accept) begin
      cnt      <= 4'(LATENCY);
      cap_addr <= req_addr;
    end else if (state == WAIT) begin
      cnt      <= abort ? 4'd0 : cnt - 4'd1;
    end
  end

  // Registered even on an aborted final WAIT edge; resp_valid alone qualifies these.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_addr <= '0;
      resp_inst <= '0;
      resp_err  <= 1'b0;
    end else if (reg_now) begin
      resp_addr <= src_addr;
      resp_inst <= in_range ? rd_word : 32'h0;
      resp_err  <= !in_range;
    end
  end

  // Program storage is cleared by reset, so the program must be reloaded afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench: three instances (LATENCY 2, 0, 3) sharing one clock.
module tb_inst_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       req_valid, req_ready, abort, resp_valid, resp_err, ld_en;
  logic [2:0][31:0] req_addr, resp_addr, resp_inst, ld_data;
  logic [2:0][5:0]  ld_addr;

  int n_pass = 0;
  int n_total = 0;

  inst_mem_responder #(.DEPTH(64), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .abort(abort[0]), .resp_valid(resp_valid[0]),
    .resp_addr(resp_addr[0]), .resp_inst(resp_inst[0]), .resp_err(resp_err[0]),
    .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]));

  inst_mem_responder #(.DEPTH(64), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .abort(abort[1]), .resp_valid(resp_valid[1]),
    .resp_addr(resp_addr[1]), .resp_inst(resp_inst[1]), .resp_err(resp_err[1]),
    .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]));

  inst_mem_responder #(.DEPTH(64), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .abort(abort[2]), .resp_valid(resp_valid[2]),
    .resp_addr(resp_addr[2]), .resp_inst(resp_inst[2]), .resp_err(resp_err[2]),
    .ld_en(ld_en[2]), .ld_addr(ld_addr[2]), .ld_data(ld_data[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Return 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d, input logic [5:0] a, input logic [31:0] w);
    ld_en[d] = 1'b1; ld_addr[d] = a; ld_data[d] = w;
    tick();
    ld_en[d] = 1'b0;
  endtask

  // Present a request so that the next edge is acceptance edge 0
  task automatic issue(input int d, input logic [31:0] a);
    req_valid[d] = 1'b1; req_addr[d] = a;
    tick();
    req_valid[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; abort = '0; ld_en = '0;
    req_addr = '0; ld_addr = '0; ld_data = '0;
    #2;
    chk("rst_ready",  32'(req_ready[0]),  32'd1);
    chk("rst_valid",  32'(resp_valid[0]), 32'd0);
    chk("rst_inst",   resp_inst[0],       32'h0);
    chk("rst_addr",   resp_addr[0],       32'h0);
    chk("rst_err",    32'(resp_err[0]),   32'd0);
    // Requests are ignored while reset is held
    req_valid[0] = 1'b1; req_addr[0] = 32'd1;
    tick();
    chk("rst_noacc",  32'(req_ready[0]),  32'd1);
    req_valid[0] = 1'b0;
    rst = 1'b1;

    // Load and fetch, LATENCY=2
    load(0, 6'd3, 32'h0022_1000);
    issue(0, 32'd3);                       // after edge 0
    chk("lf_e0_rdy",  32'(req_ready[0]),  32'd0);
    chk("lf_e0_vld",  32'(resp_valid[0]), 32'd0);
    tick();                                // edge 1
    chk("lf_e1_rdy",  32'(req_ready[0]),  32'd0);
    chk("lf_e1_vld",  32'(resp_valid[0]), 32'd0);
    tick();                                // edge 2
    chk("lf_e2_vld",  32'(resp_valid[0]), 32'd1);
    chk("lf_e2_rdy",  32'(req_ready[0]),  32'd0);
    chk("lf_inst",    resp_inst[0],       32'h0022_1000);
    chk("lf_addr",    resp_addr[0],       32'd3);
    chk("lf_err",     32'(resp_err[0]),   32'd0);
    tick();                                // edge 3
    chk("lf_e3_vld",  32'(resp_valid[0]), 32'd0);
    chk("lf_e3_rdy",  32'(req_ready[0]),  32'd1);
    chk("lf_hold",    resp_inst[0],       32'h0022_1000);

    // Out of range
    issue(0, 32'd64);
    tick();
    chk("oor_e1_vld", 32'(resp_valid[0]), 32'd0);
    tick();
    chk("oor_vld",    32'(resp_valid[0]), 32'd1);
    chk("oor_inst",   resp_inst[0],       32'h0);
    chk("oor_err",    32'(resp_err[0]),   32'd1);
    chk("oor_addr",   resp_addr[0],       32'd64);
    tick();
    chk("oor_once",   32'(resp_valid[0]), 32'd0);

    // Write collision on the registering edge
    issue(0, 32'd3);                       // edge 0
    tick();                                // edge 1
    ld_en[0] = 1'b1; ld_addr[0] = 6'd3; ld_data[0] = 32'hDEAD_0000;
    tick();                                // edge 2 registers and writes
    ld_en[0] = 1'b0;
    chk("wc_vld",     32'(resp_valid[0]), 32'd1);
    chk("wc_old",     resp_inst[0],       32'h0022_1000);
    tick();
    issue(0, 32'd3);
    tick(); tick();
    chk("wc2_vld",    32'(resp_valid[0]), 32'd1);
    chk("wc_new",     resp_inst[0],       32'hDEAD_0000);
    tick();

    // Async reset mid-WAIT
    issue(0, 32'd3);                       // edge 0
    tick();                                // edge 1, still WAIT
    #2 rst = 1'b0;
    #1;
    chk("ar_vld",     32'(resp_valid[0]), 32'd0);
    chk("ar_inst",    resp_inst[0],       32'h0);
    chk("ar_addr",    resp_addr[0],       32'h0);
    chk("ar_err",     32'(resp_err[0]),   32'd0);
    chk("ar_rdy",     32'(req_ready[0]),  32'd1);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ar_noresp", 32'(resp_valid[0]), 32'd0);
    end
    issue(0, 32'd3);
    tick(); tick();
    chk("ar_mem_vld", 32'(resp_valid[0]), 32'd1);
    chk("ar_mem_clr", resp_inst[0],       32'h0);
    tick();

    // Zero latency, back-to-back with req_valid held high
    load(1, 6'd0, 32'h1111_1111);
    load(1, 6'd1, 32'h2222_2222);
    load(1, 6'd2, 32'h3333_3333);
    req_valid[1] = 1'b1; req_addr[1] = 32'd0;
    for (int k = 0; k < 3; k++) begin
      tick();                              // acceptance edge
      chk("z_vld",  32'(resp_valid[1]), 32'd1);
      chk("z_rdy",  32'(req_ready[1]),  32'd0);
      chk("z_addr", resp_addr[1],       32'(k));
      chk("z_inst", resp_inst[1],       {4{8'(8'h11 * (k + 1))}});
      req_addr[1] = 32'(k + 1);
      tick();                              // back to IDLE
      chk("z_gap",  32'(resp_valid[1]), 32'd0);
      chk("z_rdy2", 32'(req_ready[1]),  32'd1);
    end
    req_valid[1] = 1'b0;

    // Abort, LATENCY=3
    load(2, 6'd5, 32'h5555_5555);
    issue(2, 32'd4);                       // edge 0
    abort[2] = 1'b1;
    chk("ab_vld0",    32'(resp_valid[2]), 32'd0);
    tick();                                // edge 1 aborts
    abort[2] = 1'b0;
    chk("ab_rdy",     32'(req_ready[2]),  32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ab_noresp", 32'(resp_valid[2]), 32'd0);
    end
    // Simultaneous req_valid and abort in IDLE is not accepted
    req_valid[2] = 1'b1; req_addr[2] = 32'd5; abort[2] = 1'b1;
    tick();
    abort[2] = 1'b0; req_valid[2] = 1'b0;
    chk("ab_simul",   32'(req_ready[2]),  32'd1);
    issue(2, 32'd5);                       // edge 0
    tick(); tick();
    chk("ab_e2_vld",  32'(resp_valid[2]), 32'd0);
    tick();                                // edge 3
    chk("ab_new_vld", 32'(resp_valid[2]), 32'd1);
    chk("ab_new_inst", resp_inst[2],      32'h5555_5555);
    chk("ab_new_addr", resp_addr[2],      32'd5);
    tick();
    chk("ab_new_end", 32'(resp_valid[2]), 32'd0);
    // Abort during RESP masks the strobe combinationally
    issue(2, 32'd5);
    tick(); tick(); tick();
    abort[2] = 1'b1;
    #1;
    chk("ab_resp_mask", 32'(resp_valid[2]), 32'd0);
    tick();
    abort[2] = 1'b0;
    chk("ab_resp_rdy", 32'(req_ready[2]),  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
